// File: rtl/ifetch_pkg.sv
// Shared types and tag layout for the instruction fetch front end.
// The fetch tag carries only the epoch; the remaining tag bits are zero.
package ifetch_pkg;

  localparam int EPOCH_W       = 3;
  localparam int TAG_W         = 9;
  localparam int TAG_EPOCH_LSB = 0;
  localparam int TAG_EPOCH_MSB = TAG_EPOCH_LSB + EPOCH_W - 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [TAG_W-1:0] make_tag(input logic [EPOCH_W-1:0] epoch);
    logic [TAG_W-1:0] tag;
    tag = '0;
    tag[TAG_EPOCH_MSB:TAG_EPOCH_LSB] = epoch;
    return tag;
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Small synchronous prefetch FIFO holding {pc, instr} pairs for decode.
// Flush empties the queue and wins over a push or pop in the same cycle.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush && do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: walks the PC, issues epoch-tagged word fetches to the
// instruction RAM and buffers in-epoch responses for decode.
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'hFFFF0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [31:0]      dec_instr,
  output logic [31:0]      dec_pc,
  output logic             ifetch_iram_request,
  input  logic             ifetch_iram_ready,
  output logic [31:0]      ifetch_iram_address,
  output logic [31:0]      ifetch_iram_wdata,
  input  logic [31:0]      ifetch_iram_rdata,
  input  logic [31:0]      ifetch_iram_raddr,
  input  logic [TAG_W-1:0] ifetch_iram_rtag,
  input  logic             ifetch_iram_rvalid
);

  localparam int              CNT_W       = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W:0]  DEPTH_LIMIT = (CNT_W + 1)'(QUEUE_DEPTH);

  logic [31:0]        pc_q;
  logic [EPOCH_W-1:0] epoch_q;
  logic [CNT_W-1:0]   outstanding_q;
  logic [CNT_W-1:0]   queue_count;
  logic [CNT_W:0]     credits_used;
  logic               accept;
  logic               resp_counted;
  logic               push;
  logic               pop;
  logic               q_empty;
  logic               q_full;
  fetch_entry_t       push_entry;
  fetch_entry_t       head;
  logic               unused_tag_bits;

  // Every queued or in-flight word holds a slot, so a response always has room.
  assign credits_used = {1'b0, queue_count} + {1'b0, outstanding_q};

  assign ifetch_iram_request = !reset && !redirect_valid && (credits_used < DEPTH_LIMIT);
  assign ifetch_iram_address = pc_q;
  assign ifetch_iram_wdata   = {{(32 - TAG_W){1'b0}}, make_tag(epoch_q)};
  assign accept              = ifetch_iram_request && ifetch_iram_ready;

  // A response with nothing outstanding belongs to a pre-reset request.
  assign resp_counted = ifetch_iram_rvalid && (outstanding_q != '0);
  assign push         = resp_counted && !redirect_valid &&
                        (ifetch_iram_rtag[TAG_EPOCH_MSB:TAG_EPOCH_LSB] == epoch_q);
  assign pop          = dec_valid && dec_ready && !redirect_valid;

  assign push_entry.pc    = ifetch_iram_raddr;
  assign push_entry.instr = ifetch_iram_rdata;
  assign unused_tag_bits  = ^ifetch_iram_rtag[TAG_W-1:EPOCH_W];

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= {RESET_PC[31:2], 2'b00};
      epoch_q       <= '0;
      outstanding_q <= '0;
    end else begin
      if (redirect_valid) begin
        pc_q    <= {redirect_pc[31:2], 2'b00};
        epoch_q <= epoch_q + 1'b1;
      end else if (accept) begin
        pc_q <= pc_q + 32'd4;
      end
      outstanding_q <= outstanding_q + CNT_W'(accept) - CNT_W'(resp_counted);
    end
  end

  ifetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .empty      (q_empty),
    .full       (q_full),
    .count      (queue_count)
  );

  assign dec_valid = !q_empty;
  assign dec_pc    = q_empty ? '0 : head.pc;
  assign dec_instr = q_empty ? '0 : head.instr;

  assert property (@(posedge clock) disable iff (reset) !(push && q_full));

endmodule
